// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM encoding and start-validation helper for the
// instruction-memory loader.
package imem_loader_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int MAX_WORDS_DEF = 64;
  localparam int NUM_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A load request is legal only for 1..max_words words.
  function automatic logic num_words_ok(input logic [NUM_W-1:0] n, input int max_words);
    return (n != 7'd0) && (32'(n) <= max_words);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four incoming bytes into a little-endian 32-bit instruction word.
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic        last_byte
);

  logic [1:0]  byte_cnt_r;
  logic [31:0] word_r;

  // word_next includes the byte on the bus so the 4th byte is visible at the WRITE transition
  always_comb begin
    word_next = word_r;
    case (byte_cnt_r)
      2'd0:    word_next[7:0]   = byte_data;
      2'd1:    word_next[15:8]  = byte_data;
      2'd2:    word_next[23:16] = byte_data;
      2'd3:    word_next[31:24] = byte_data;
      default: word_next        = word_r;
    endcase
  end

  assign last_byte = accept && (byte_cnt_r == 2'd3);

  // Byte counter and packing register; the counter wraps after the 4th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r <= 2'd0;
      word_r     <= 32'd0;
    end else if (clear) begin
      byte_cnt_r <= 2'd0;
      word_r     <= 32'd0;
    end else if (accept) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      word_r     <= word_next;
    end else begin
      byte_cnt_r <= byte_cnt_r;
      word_r     <= word_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes from a source into instruction memory, one 32-bit word per
// write strobe, holding the core while the load is in progress.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t           state_r;
  state_t           state_next_s;
  logic [NUM_W-1:0] num_words_r;
  logic [NUM_W-1:0] word_cnt_r;
  logic             start_ok_s;
  logic             start_acc_s;
  logic             accept_s;
  logic             last_word_s;
  logic             last_byte_s;
  logic [31:0]      word_next_s;

  assign start_ok_s  = num_words_ok(num_words, MAX_WORDS);
  assign start_acc_s = (state_r == ST_IDLE) && start && start_ok_s;
  // byte_ready is a registered image of (state_r == ST_RECV)
  assign accept_s    = byte_ready && byte_valid;
  assign last_word_s = (word_cnt_r + 7'd1) == num_words_r;

  imem_loader_byte_packer u_byte_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc_s),
    .accept    (accept_s),
    .byte_data (byte_data),
    .word_next (word_next_s),
    .last_byte (last_byte_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_next_s = ST_RECV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (last_byte_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RECV;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Word counter, latched length and the memory write address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_words_r <= 7'd0;
      word_cnt_r  <= 7'd0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_acc_s) begin
            num_words_r <= num_words;
            word_cnt_r  <= 7'd0;
          end
        end
        ST_RECV: begin
          if (last_byte_s) begin
            imem_addr  <= {word_cnt_r[ADDR_W-3:0], 2'b00};
            imem_wdata <= word_next_s;
          end
        end
        ST_WRITE: begin
          if (!last_word_s) begin
            word_cnt_r <= word_cnt_r + 7'd1;
          end
        end
        default: begin
          word_cnt_r <= word_cnt_r;
        end
      endcase
    end
  end

  // Status outputs are registered from the upcoming state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      byte_ready <= (state_next_s == ST_RECV);
      imem_we    <= (state_next_s == ST_WRITE);
      busy       <= (state_next_s != ST_IDLE);
      cpu_hold   <= (state_next_s != ST_IDLE);
      done       <= (state_next_s == ST_DONE);
      err        <= (state_r == ST_IDLE) && start && !start_ok_s;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table of single-word and rejected
// loads, plus hand-written multi-word, reset-abort, restart and full-size sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  we_addr_q[$];
  logic [31:0] we_data_q[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;

  always @(posedge clk) begin
    if (imem_we) begin
      we_addr_q.push_back(imem_addr);
      we_data_q.push_back(imem_wdata);
    end
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  typedef struct {
    logic [6:0]  nw;
    logic [7:0]  b0, b1, b2, b3;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] nw);
    num_words = nw;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (byte_ready) tick();
    else check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          we_base;
    int          done_base;
    int          err_base;
    logic [7:0]  bytes[256];
    logic [31:0] exp_words[64];

    vecs[0] = '{7'd1,  8'h13, 8'h05, 8'h10, 8'h00, 1'b0, 32'h0010_0513};
    vecs[1] = '{7'd0,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0};
    vecs[2] = '{7'd1,  8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{7'd65, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0};
    vecs[4] = '{7'd1,  8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 32'h0403_0201};
    vecs[5] = '{7'd127,8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0};
    vecs[6] = '{7'd1,  8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 32'h00FF_00FF};
    vecs[7] = '{7'd1,  8'h00, 8'h00, 8'h00, 8'h80, 1'b0, 32'h8000_0000};

    rst = 1'b1; start = 1'b0; num_words = 7'd0; byte_valid = 1'b0; byte_data = 8'd0;
    tick();
    tick();
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_imem_we",    {31'd0, imem_we},    32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_err",        {31'd0, err},        32'd0);
    check("rst_addr",       {24'd0, imem_addr},  32'd0);
    check("rst_wdata",      imem_wdata,          32'd0);
    rst = 1'b0;
    tick();

    // Table: single-word loads and rejected starts.
    for (int v = 0; v < 8; v++) begin
      we_base = we_addr_q.size(); done_base = done_cnt; err_base = err_cnt;
      do_start(vecs[v].nw);
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d_err_pulse", v), {31'd0, err},  32'd1);
        check($sformatf("v%0d_err_busy", v),  {31'd0, busy}, 32'd0);
        tick();
        check($sformatf("v%0d_err_clear", v), {31'd0, err},  32'd0);
        check($sformatf("v%0d_err_busy2", v), {31'd0, busy | cpu_hold}, 32'd0);
        check($sformatf("v%0d_err_cnt", v), err_cnt - err_base, 32'd1);
      end else begin
        check($sformatf("v%0d_busy", v),     {31'd0, busy},     32'd1);
        check($sformatf("v%0d_hold", v),     {31'd0, cpu_hold}, 32'd1);
        send_byte(vecs[v].b0, 0);
        send_byte(vecs[v].b1, 0);
        send_byte(vecs[v].b2, 0);
        send_byte(vecs[v].b3, 0);
        check($sformatf("v%0d_we", v),       {31'd0, imem_we},    32'd1);
        check($sformatf("v%0d_rdy_wr", v),   {31'd0, byte_ready}, 32'd0);
        check($sformatf("v%0d_addr", v),     {24'd0, imem_addr},  32'd0);
        check($sformatf("v%0d_wdata", v),    imem_wdata,          vecs[v].exp_word);
        tick();
        check($sformatf("v%0d_we_off", v),   {31'd0, imem_we},    32'd0);
        check($sformatf("v%0d_done", v),     {31'd0, done},       32'd1);
        tick();
        check($sformatf("v%0d_done_off", v), {31'd0, done},       32'd0);
        check($sformatf("v%0d_hold_off", v), {31'd0, cpu_hold | busy}, 32'd0);
        check($sformatf("v%0d_done_cnt", v), done_cnt - done_base, 32'd1);
      end
      check($sformatf("v%0d_strobes", v), we_addr_q.size() - we_base,
            vecs[v].exp_err ? 32'd0 : 32'd1);
    end

    // Three words with random valid gaps.
    we_base = we_addr_q.size(); done_base = done_cnt;
    for (int i = 0; i < 12; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 3; w++)
      exp_words[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
    do_start(7'd3);
    for (int i = 0; i < 12; i++) send_byte(bytes[i], $urandom_range(0, 3));
    wait_idle(20);
    check("w3_strobes", we_addr_q.size() - we_base, 32'd3);
    for (int w = 0; w < 3; w++) begin
      check($sformatf("w3_addr%0d", w), {24'd0, we_addr_q[we_base+w]}, 32'(4*w));
      check($sformatf("w3_data%0d", w), we_data_q[we_base+w], exp_words[w]);
    end
    check("w3_done_cnt", done_cnt - done_base, 32'd1);

    // Reset mid-load after two words and two bytes.
    we_base = we_addr_q.size(); done_base = done_cnt;
    do_start(7'd4);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",  {31'd0, busy | cpu_hold}, 32'd0);
    check("abort_ready", {31'd0, byte_ready},      32'd0);
    check("abort_addr",  {24'd0, imem_addr},       32'd0);
    check("abort_wdata", imem_wdata,               32'd0);
    repeat (6) tick();
    check("abort_strobes", we_addr_q.size() - we_base, 32'd2);
    check("abort_no_done", done_cnt - done_base, 32'd0);
    we_base = we_addr_q.size(); done_base = done_cnt;
    do_start(7'd1);
    send_byte(8'h93, 1); send_byte(8'h00, 0); send_byte(8'h10, 2); send_byte(8'h00, 0);
    wait_idle(10);
    check("fresh_strobes", we_addr_q.size() - we_base, 32'd1);
    check("fresh_addr", {24'd0, we_addr_q[we_base]}, 32'd0);
    check("fresh_data", we_data_q[we_base], 32'h0010_0093);
    check("fresh_done", done_cnt - done_base, 32'd1);

    // Start pulses during RECV are ignored, including an invalid length.
    we_base = we_addr_q.size(); done_base = done_cnt; err_base = err_cnt;
    do_start(7'd2);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    do_start(7'd1);
    do_start(7'd0);
    send_byte(8'h33, 0); send_byte(8'h44, 1);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    wait_idle(20);
    check("restart_strobes", we_addr_q.size() - we_base, 32'd2);
    check("restart_data0", we_data_q[we_base],   32'h4433_2211);
    check("restart_addr1", {24'd0, we_addr_q[we_base+1]}, 32'h04);
    check("restart_data1", we_data_q[we_base+1], 32'h8877_6655);
    check("restart_done", done_cnt - done_base, 32'd1);
    check("restart_no_err", err_cnt - err_base, 32'd0);

    // Full 64-word load.
    we_base = we_addr_q.size(); done_base = done_cnt;
    for (int i = 0; i < 256; i++) bytes[i] = 8'(i * 37 + 5);
    for (int w = 0; w < 64; w++)
      exp_words[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
    do_start(7'd64);
    for (int i = 0; i < 256; i++) send_byte(bytes[i], (i % 7 == 3) ? 1 : 0);
    wait_idle(20);
    check("full_strobes", we_addr_q.size() - we_base, 32'd64);
    for (int w = 0; w < 64; w++) begin
      check($sformatf("full_addr%0d", w), {24'd0, we_addr_q[we_base+w]}, 32'(4*w));
      check($sformatf("full_data%0d", w), we_data_q[we_base+w], exp_words[w]);
    end
    check("full_last_addr", {24'd0, we_addr_q[we_addr_q.size()-1]}, 32'hFC);
    check("full_done", done_cnt - done_base, 32'd1);
    check("full_hold_off", {31'd0, cpu_hold}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
